// File: rtl/rsa_crypt_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine:
// operand width helper and controller state encoding.
package rsa_crypt_pkg;

  // Key, modulus and text are twice the prime width.
  function automatic int key_w(input int width);
    return 2 * width;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/rsa_crypt_if.sv
// Job/result handshake between the text source/sink and the RSA engine.
interface rsa_crypt_if
  import rsa_crypt_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int KW = key_w(WIDTH);

  logic          in_valid;
  logic          in_ready;
  logic [KW-1:0] in_text;
  logic [KW-1:0] in_key;
  logic [KW-1:0] in_n;
  logic          out_valid;
  logic [KW-1:0] out_text;

  modport master (
    output in_valid, in_text, in_key, in_n,
    input  in_ready, out_valid, out_text
  );

  modport slave (
    input  in_valid, in_text, in_key, in_n,
    output in_ready, out_valid, out_text
  );
endinterface

// File: rtl/rsa_crypt_modmul.sv
// Combinational (a*b) mod n via shift-subtract reduction of the full product;
// result is forced to 0 when n==0.
module rsa_crypt_modmul
  import rsa_crypt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [key_w(WIDTH)-1:0] a,
  input  logic [key_w(WIDTH)-1:0] b,
  input  logic [key_w(WIDTH)-1:0] n,
  output logic [key_w(WIDTH)-1:0] r
);
  localparam int KW = key_w(WIDTH);
  localparam int PW = 2 * KW;

  logic [PW-1:0] prod;
  logic [KW:0]   rem;

  always_comb begin
    prod = PW'(a) * PW'(b);
    rem  = '0;
    // rem stays below n, so one conditional subtract per shifted bit suffices.
    for (int i = PW - 1; i >= 0; i--) begin
      rem = {rem[KW-1:0], prod[i]};
      if (rem >= {1'b0, n}) begin
        rem = rem - {1'b0, n};
      end
    end
    r = (n == '0) ? '0 : rem[KW-1:0];
  end
endmodule

// File: rtl/rsa_crypt.sv
// RSA encrypt/decrypt engine: out_text = in_text^in_key mod in_n using
// right-to-left square-and-multiply, one exponent bit per cycle, fixed latency.
//
// state  | meaning
// S_IDLE | ready; capture operands on in_valid
// S_CALC | KEY_W square-and-multiply iterations
// S_OUT  | out_valid pulse, return to idle
module rsa_crypt
  import rsa_crypt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  rsa_crypt_if.slave  bus
);
  localparam int KW = key_w(WIDTH);
  localparam int CW = $clog2(KW);

  state_t        state_q, state_d;
  logic [KW-1:0] base_q, acc_q, exp_q, n_q, out_text_q;
  logic [CW-1:0] count_q;
  logic          out_valid_q;

  logic [KW-1:0] mul_a, mul_b, sq_a, sq_b, mod_n;
  logic [KW-1:0] mul_res, sq_res, acc_next;
  logic          last_iter;

  // In idle the two reducers are borrowed for the capture-time reductions.
  always_comb begin
    mul_a = acc_q;
    mul_b = base_q;
    sq_a  = base_q;
    sq_b  = base_q;
    mod_n = n_q;
    if (state_q == S_IDLE) begin
      mul_a = KW'(1);
      mul_b = KW'(1);
      sq_a  = bus.in_text;
      sq_b  = KW'(1);
      mod_n = bus.in_n;
    end
  end

  rsa_crypt_modmul #(.WIDTH(WIDTH)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .n (mod_n),
    .r (mul_res)
  );

  rsa_crypt_modmul #(.WIDTH(WIDTH)) u_sq (
    .a (sq_a),
    .b (sq_b),
    .n (mod_n),
    .r (sq_res)
  );

  assign acc_next  = exp_q[0] ? mul_res : acc_q;
  assign last_iter = (count_q == CW'(KW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_CALC;
      S_CALC:  if (last_iter) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      acc_q       <= '0;
      exp_q       <= '0;
      n_q         <= '0;
      count_q     <= '0;
      out_text_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            n_q     <= bus.in_n;
            exp_q   <= bus.in_key;
            base_q  <= sq_res;
            acc_q   <= mul_res;
            count_q <= '0;
          end
        end
        S_CALC: begin
          acc_q   <= acc_next;
          base_q  <= sq_res;
          exp_q   <= exp_q >> 1;
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            out_text_q  <= acc_next;
            out_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_text  = out_text_q;
endmodule

// File: tb/tb_rsa_crypt.sv
// Self-checking bench for rsa_crypt: directed vector table, busy/reset
// sequences and random jobs against a repeated-multiplication reference.
module tb_rsa_crypt;
  localparam int WIDTH = 4;
  localparam int KW    = 2 * WIDTH;
  localparam int LAT   = KW;

  logic clk;
  logic rst;

  rsa_crypt_if #(.WIDTH(WIDTH)) bus ();

  rsa_crypt #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int pulse_cnt   = 0;
  int pulse_viol  = 0;
  int stab_viol   = 0;
  int exp_pulses  = 0;
  bit prev_ov     = 1'b0;
  logic [KW-1:0] last_out = '0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: base^key mod n by plain repeated multiplication.
  function automatic logic [KW-1:0] ref_pow(input int t, input int k, input int n);
    longint r;
    if (n == 0) return '0;
    r = 1 % n;
    for (int i = 0; i < k; i++) r = (r * t) % n;
    return KW'(r);
  endfunction

  // Output monitor: single-cycle pulses, out_text stable between results.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      prev_ov  = 1'b0;
      last_out = bus.out_text;
    end else begin
      if (bus.out_valid) begin
        pulse_cnt++;
        if (prev_ov) pulse_viol++;
        last_out = bus.out_text;
      end else if (bus.out_text != last_out) begin
        stab_viol++;
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (w >= 30) check("ready_timeout", 0, 1);
  endtask

  task automatic run_job(input logic [KW-1:0] t, input logic [KW-1:0] k,
                         input logic [KW-1:0] n, output logic [KW-1:0] res,
                         output int lat);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_text  = t;
    bus.in_key   = k;
    bus.in_n     = n;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_text  = KW'($urandom);
    bus.in_key   = KW'($urandom);
    bus.in_n     = KW'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    res = bus.out_text;
    exp_pulses++;
  endtask

  typedef struct {
    logic [KW-1:0] t;
    logic [KW-1:0] k;
    logic [KW-1:0] n;
    logic [KW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [KW-1:0] res;
    int lat;
    int pcs[$];
    logic [KW-1:0] pvals[$];
    int p0;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_text  = '0;
    bus.in_key   = '0;
    bus.in_n     = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_text", bus.out_text, 0);
    rst = 1'b0;

    vecs.push_back('{8'd4,  8'd3, 8'd33, 8'd31});
    vecs.push_back('{8'd31, 8'd7, 8'd33, 8'd4});
    vecs.push_back('{8'd2,  8'd5, 8'd35, 8'd32});
    vecs.push_back('{8'd32, 8'd5, 8'd35, 8'd2});
    vecs.push_back('{8'd9,  8'd0, 8'd35, 8'd1});
    vecs.push_back('{8'd40, 8'd1, 8'd35, 8'd5});
    vecs.push_back('{8'd7,  8'd5, 8'd1,  8'd0});
    vecs.push_back('{8'd9,  8'd0, 8'd1,  8'd0});
    vecs.push_back('{8'd9,  8'd0, 8'd0,  8'd0});
    vecs.push_back('{8'd40, 8'd1, 8'd0,  8'd0});
    vecs.push_back('{8'd4,  8'd3, 8'd0,  8'd0});
    vecs.push_back('{8'd255, 8'd255, 8'd255, 8'd0});

    foreach (vecs[i]) begin
      run_job(vecs[i].t, vecs[i].k, vecs[i].n, res, lat);
      check($sformatf("vec%0d_text", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Busy: in_valid held for 20 cycles, inputs disturbed mid-CALC.
    wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      if ((i >= 2 && i <= 5) || (i >= 12 && i <= 15)) begin
        bus.in_text = 8'd9;
        bus.in_key  = 8'd0;
        bus.in_n    = 8'd35;
      end else begin
        bus.in_text = 8'd4;
        bus.in_key  = 8'd3;
        bus.in_n    = 8'd33;
      end
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        pcs.push_back(i);
        pvals.push_back(bus.out_text);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_pulses += 2;
    check("busy_pulse_count", pcs.size(), 2);
    if (pcs.size() == 2) begin
      check("busy_first_pulse", pcs[0], LAT);
      // Nine quiet cycles separate the two result pulses.
      check("busy_pulse_gap", pcs[1] - pcs[0], 10);
      check("busy_res0", pvals[0], 31);
      check("busy_res1", pvals[1], 31);
    end

    // Reset three cycles into CALC aborts the job silently.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_text  = 8'd4;
    bus.in_key   = 8'd3;
    bus.in_n     = 8'd33;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    p0  = pulse_cnt;
    rst = 1'b1;
    #1;
    check("abort_out_text", bus.out_text, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_pulse", pulse_cnt - p0, 0);
    check("abort_out_text_hold", bus.out_text, 0);
    run_job(8'd31, 8'd7, 8'd33, res, lat);
    check("after_abort_text", res, 4);
    check("after_abort_latency", lat, LAT);

    for (int j = 0; j < 1000; j++) begin
      logic [KW-1:0] t, k, n;
      t = KW'($urandom_range(0, 255));
      k = KW'($urandom_range(0, 255));
      case ($urandom_range(0, 15))
        0:       n = 8'd0;
        1:       n = 8'd1;
        default: n = KW'($urandom_range(0, 255));
      endcase
      run_job(t, k, n, res, lat);
      check($sformatf("rand%0d_text(t=%0d k=%0d n=%0d)", j, t, k, n), res, ref_pow(t, k, n));
      check($sformatf("rand%0d_latency", j), lat, LAT);
    end

    repeat (3) @(negedge clk);
    check("pulse_single_cycle", pulse_viol, 0);
    check("out_text_stable", stab_viol, 0);
    check("pulse_total", pulse_cnt, exp_pulses);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
